mem_mask_unit: RTL and testbench
================================

// Module: mem_mask_unit
// PURPOSE
//  Parametrised load/store masking unit between the MEM-stage datapath and data memory.
//  Accepts one access per handshake and produces the memory byte enables and lane-shifted write data.
//  For loads, it extracts the addressed byte/half/word/dword and sign- or zero-extends it.
//  Sequenced by an FSM that waits a fixed memory read latency. Misaligned or unsupported sizes return an error without touching memory.
// PARAMETERS
//  DATA_W   32  memory word width; 32 or 64 only
//  ADDR_W   32  byte-address width
//  MEM_LAT  1   cycles from MemEn sampled to MemRData valid; >=1
// PORTS
//  Clk        in   1         clock; all state on rising edge
//  Reset      in   1         synchronous, active-high reset
//  ReqValid   in   1         request present
//  ReqReady   out  1         unit can accept (high only in IDLE)
//  ReqWrite   in   1         1=store, 0=load
//  ReqSize    in   2         0=byte 1=half 2=word 3=dword
//  ReqSigned  in   1         loads: 1=sign-extend, 0=zero-extend
//  ReqAddr    in   ADDR_W    byte address
//  ReqData    in   DATA_W    store data, right-aligned
//  MemEn      out  1         memory access strobe, one cycle per access
//  MemWe      out  1         write strobe (with MemEn)
//  MemAddr    out  ADDR_W    word-aligned address (low log2(DATA_W/8) bits 0)
//  MemByteEn  out  DATA_W/8  byte lane enables
//  MemWData   out  DATA_W    write data shifted to lane
//  MemRData   in   DATA_W    read data
//  RespValid  out  1         response held until RespReady
//  RespReady  in   1         consumer accepts response
//  RespData   out  DATA_W    extended load data; 0 for stores/errors
//  RespErr    out  1         misaligned address or size unsupported at DATA_W
// BEHAVIOUR
//  Reset: FSM=IDLE; ReqReady=1; all other outputs 0, including RespData and wait counter.
//  Reset wins over every event and aborts an in-flight access; no response is issued for it.
//  Accept on ReqValid&&ReqReady at cycle T; request fields are registered then.
//  Alignment is required on address bits [size-1:0]. ReqSize=3 with DATA_W=32 is an error.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//   IDLE -> ISSUE when a legal request is accepted.
//   IDLE -> RESP when an illegal request is accepted (RespErr=1, no MemEn).
//   ISSUE (T+1): MemEn=1 and MemWe=ReqWrite for exactly this cycle.
//    Store: -> RESP.
//    Load: -> WAIT with counter=MEM_LAT-1.
//   WAIT: capture MemRData when counter==0 (cycle T+1+MEM_LAT), -> RESP; otherwise decrement.
//   RESP: RespValid=1 with RespData/RespErr stable; on RespReady -> IDLE.
//  Latency: store resp at T+2; load resp at T+2+MEM_LAT; error resp at T+1.
//  Lane = ReqAddr[log2(DATA_W/8)-1:0].
//   MemByteEn = ((1<<(1<<size))-1) << lane.
//   MemWData = ReqData << (8*lane).
//  Load extract: (MemRData >> 8*lane), truncated to 8<<size bits; the MSB is replicated if ReqSigned.
//  MemByteEn, MemWData and MemAddr are 0 outside ISSUE.
//  ReqValid in non-IDLE states is ignored (ReqReady=0); no requests are queued.
// STRUCTURE
//  Shared package mem_pkg:
//   size localparams SZ_B/SZ_H/SZ_W/SZ_D;
//   FSM state encoding;
//   function lane_mask(size,lane).
//  One sub-module, mem_load_extend: combinational extract+extend (DATA_W, lane, size, signed).
//  Used in WAIT capture.
// TESTING
//  1. DATA_W=32, store byte 0xAB at addr 0x13 -> MemByteEn=4'b1000, MemWData=0xAB000000, MemAddr=0x10, resp T+2.
//  2. Load half signed addr 0x22, MemRData=0x8001_1234 -> RespData=0xFFFF8001; unsigned -> 0x00008001.
//  3. Load word addr 0x21 -> RespErr=1 at T+1, MemEn never asserted, RespData=0.
//  4. MEM_LAT=3, load byte signed addr 0x0, MemRData=0x7F -> RespValid at T+5, data 0x0000007F.
//  5. DATA_W=64, dword store addr 0x8 -> MemByteEn=8'hFF; ReqSize=3 at DATA_W=32 -> RespErr=1.
//  6. RespReady low 4 cycles -> RespValid/Data held, ReqReady=0. Reset during WAIT -> IDLE next cycle, no RespValid.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: access sizes, FSM encoding and byte-lane helper shared by the load/store mask unit
package mem_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  function automatic logic [15:0] lane_mask(input logic [1:0] size, input logic [2:0] lane);
    return ((16'd1 << (5'd1 << size)) - 16'd1) << lane;
  endfunction
endpackage

// File: rtl/mem_load_extend.sv
// mem_load_extend: pulls the addressed byte/half/word/dword out of a memory word and sign/zero-extends it
module mem_load_extend import mem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int LW = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [LW-1:0]     lane,
  input  logic [1:0]        size,
  input  logic              sext,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] keep;
  logic              msb;
  always_comb begin
    sh = rdata >> {lane, 3'b000};
    keep = ~({DATA_W{1'b1}} << (8 << size));
    msb = size == SZ_B ? sh[7] : size == SZ_H ? sh[15] : size == SZ_W ? sh[31] : sh[DATA_W-1];
    data = (sh & keep) | ({DATA_W{sext & msb}} & ~keep);
  end
endmodule

// File: rtl/mem_mask_unit.sv
// mem_mask_unit: MEM-stage load/store masking unit; one access per handshake, fixed-latency reads,
// misaligned or unsupported accesses answered with an error and never reach memory.
module mem_mask_unit import mem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic                ReqWrite,
  input  logic [1:0]          ReqSize,
  input  logic                ReqSigned,
  input  logic [ADDR_W-1:0]   ReqAddr,
  input  logic [DATA_W-1:0]   ReqData,
  output logic                MemEn,
  output logic                MemWe,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic [DATA_W/8-1:0] MemByteEn,
  output logic [DATA_W-1:0]   MemWData,
  input  logic [DATA_W-1:0]   MemRData,
  output logic                RespValid,
  input  logic                RespReady,
  output logic [DATA_W-1:0]   RespData,
  output logic                RespErr
);
  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  state_e            state_q, state_d;
  logic              write_q, write_d, sext_q, sext_d;
  logic [1:0]        size_q, size_d;
  logic [LW-1:0]     lane_q, lane_d, lane;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d, ext_data;
  logic              resp_err_q, resp_err_d, bad;
  logic              req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  mem_load_extend #(.DATA_W(DATA_W)) u_ext (
    .rdata(MemRData),
    .lane (lane_q),
    .size (size_q),
    .sext (sext_q),
    .data (ext_data)
  );
  always_comb begin
    lane = ReqAddr[LW-1:0];
    bad = (ReqSize == SZ_D && DATA_W == 32) || |(ReqAddr[2:0] & 3'((4'd1 << ReqSize) - 4'd1));
    state_d = state_q;
    write_d = write_q;
    sext_d = sext_q;
    size_d = size_q;
    lane_d = lane_q;
    cnt_d = cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d = resp_err_q;
    case (state_q)
      IDLE: if (ReqValid) begin
        write_d = ReqWrite;
        sext_d = ReqSigned;
        size_d = ReqSize;
        lane_d = lane;
        resp_data_d = '0;
        resp_err_d = bad;
        state_d = bad ? RESP : ISSUE;
      end
      ISSUE: begin
        state_d = write_q ? RESP : WAIT;
        cnt_d = CW'(MEM_LAT - 1);
      end
      WAIT: if (cnt_q == '0) begin
        state_d = RESP;
        resp_data_d = ext_data;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      default: if (RespReady) begin
        state_d = IDLE;
        resp_data_d = '0;
        resp_err_d = 1'b0;
      end
    endcase
    // memory strobes are registered so they appear for exactly the ISSUE cycle
    mem_en_d = state_q == IDLE && state_d == ISSUE;
    mem_we_d = mem_en_d & ReqWrite;
    mem_addr_d = mem_en_d ? ReqAddr & ~ADDR_W'(NB - 1) : '0;
    mem_be_d = mem_en_d ? NB'(lane_mask(ReqSize, 3'(lane))) : '0;
    mem_wdata_d = mem_en_d ? ReqData << {lane, 3'b000} : '0;
    req_ready_d = state_d == IDLE;
    resp_valid_d = state_d == RESP;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      sext_q <= 1'b0;
      size_q <= '0;
      lane_q <= '0;
      cnt_q <= '0;
      resp_data_q <= '0;
      resp_err_q <= 1'b0;
      req_ready_q <= 1'b1;
      resp_valid_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_be_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      sext_q <= sext_d;
      size_q <= size_d;
      lane_q <= lane_d;
      cnt_q <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q <= resp_err_d;
      req_ready_q <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign ReqReady = req_ready_q;
  assign MemEn = mem_en_q;
  assign MemWe = mem_we_q;
  assign MemAddr = mem_addr_q;
  assign MemByteEn = mem_be_q;
  assign MemWData = mem_wdata_q;
  assign RespValid = resp_valid_q;
  assign RespData = resp_data_q;
  assign RespErr = resp_err_q;
endmodule

// File: tb/tb_mem_mask_unit.sv
// tb_mem_mask_unit: drives a 32-bit/MEM_LAT=1 unit and a 64-bit/MEM_LAT=3 unit with identical requests
// and checks both against a byte-level reference model.
module tb_mem_mask_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, req_valid, req_write, req_signed;
  logic [1:0] req_size;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [63:0] rdata [2];
  logic resp_ready [2];
  logic rr [2], en [2], we [2], rv [2], re [2];
  logic [31:0] ma [2];
  logic [7:0] be [2];
  logic [63:0] wd [2], rd [2];
  logic [3:0] be32;
  logic [31:0] wd32, rd32;
  int npass = 0, ntot = 0;
  localparam int LAT [2] = '{1, 3};
  mem_mask_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) dut32 (
    .Clk(clk), .Reset(rst), .ReqValid(req_valid), .ReqReady(rr[0]), .ReqWrite(req_write),
    .ReqSize(req_size), .ReqSigned(req_signed), .ReqAddr(req_addr), .ReqData(req_data[31:0]),
    .MemEn(en[0]), .MemWe(we[0]), .MemAddr(ma[0]), .MemByteEn(be32), .MemWData(wd32),
    .MemRData(rdata[0][31:0]), .RespValid(rv[0]), .RespReady(resp_ready[0]), .RespData(rd32),
    .RespErr(re[0])
  );
  mem_mask_unit #(.DATA_W(64), .ADDR_W(32), .MEM_LAT(3)) dut64 (
    .Clk(clk), .Reset(rst), .ReqValid(req_valid), .ReqReady(rr[1]), .ReqWrite(req_write),
    .ReqSize(req_size), .ReqSigned(req_signed), .ReqAddr(req_addr), .ReqData(req_data),
    .MemEn(en[1]), .MemWe(we[1]), .MemAddr(ma[1]), .MemByteEn(be[1]), .MemWData(wd[1]),
    .MemRData(rdata[1]), .RespValid(rv[1]), .RespReady(resp_ready[1]), .RespData(rd[1]),
    .RespErr(re[1])
  );
  assign be[0] = {4'h0, be32};
  assign wd[0] = {32'h0, wd32};
  assign rd[0] = {32'h0, rd32};

  function automatic logic [63:0] wmask(int i);
    return i == 1 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] load_model(logic [63:0] r, int ln, int sz, bit sg, int i);
    int nbits = 8 << sz;
    logic [63:0] v = r >> (8 * ln);
    logic [63:0] res = '0;
    for (int b = 0; b < nbits; b++) res[b] = v[b];
    if (sg && v[nbits-1]) for (int b = nbits; b < 64; b++) res[b] = 1'b1;
    return res & wmask(i);
  endfunction

  task automatic chk(input string tag, input int i, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s dut%0d: got %h expected %h", tag, i, got, exp);
  endtask

  task automatic idle_chk(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_ready"}, i, rr[i], 1);
      chk({tag, "_rvalid"}, i, rv[i], 0);
      chk({tag, "_en"}, i, en[i], 0);
    end
  endtask

  task automatic do_txn(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] ad,
                        input logic [63:0] dt, input logic [63:0] rval, input int hold, input bit noise);
    bit err [2], done [2], hs [2];
    int rc [2], hd [2], nb, ln;
    logic [63:0] exp_be [2], exp_wd [2], exp_rd [2], exp_ma [2], rv_val [2];
    for (int i = 0; i < 2; i++) begin
      nb = i == 1 ? 8 : 4;
      ln = int'(ad % nb);
      err[i] = (sz == 2'd3 && i == 0) || (ad % (32'd1 << sz)) != 0;
      rv_val[i] = rval & wmask(i);
      exp_be[i] = '0;
      for (int b = ln; b < ln + (1 << sz) && b < nb; b++) exp_be[i][b] = 1'b1;
      exp_wd[i] = (dt & wmask(i)) << (8 * ln) & wmask(i);
      exp_ma[i] = 64'(ad - ad % nb);
      exp_rd[i] = (err[i] || wr) ? 64'h0 : load_model(rv_val[i], ln, int'(sz), sg, i);
      rc[i] = err[i] ? 1 : wr ? 2 : 2 + LAT[i];
      hd[i] = hold < 0 ? int'($urandom_range(0, 4)) : hold;
      done[i] = 1'b0;
    end
    req_valid = 1'b1;
    req_write = wr;
    req_size = sz;
    req_signed = sg;
    req_addr = ad;
    req_data = dt;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 40 && !(done[0] && done[1]); c++) begin
      for (int i = 0; i < 2; i++) begin
        rdata[i] = c == 1 + LAT[i] ? rv_val[i] : {$urandom, $urandom};
        resp_ready[i] = !done[i] && c >= rc[i] + hd[i];
      end
      req_valid = noise && !rr[0] && !rr[1];
      if (req_valid) begin
        req_write = 1'($urandom_range(0, 1));
        req_size = 2'($urandom);
        req_addr = $urandom;
        req_data = {$urandom, $urandom};
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (done[i]) begin
          chk("post_ready", i, rr[i], 1);
          chk("post_rvalid", i, rv[i], 0);
          chk("post_en", i, en[i], 0);
        end else begin
          chk("mem_en", i, en[i], !err[i] && c == 1);
          chk("mem_we", i, we[i], !err[i] && c == 1 && wr);
          chk("byte_en", i, be[i], (!err[i] && c == 1) ? exp_be[i] : 64'h0);
          chk("wdata", i, wd[i], (!err[i] && c == 1) ? exp_wd[i] : 64'h0);
          chk("mem_addr", i, ma[i], (!err[i] && c == 1) ? exp_ma[i] : 64'h0);
          chk("busy_ready", i, rr[i], 0);
          chk("resp_valid", i, rv[i], c >= rc[i]);
          if (c >= rc[i]) begin
            chk("resp_data", i, rd[i], exp_rd[i]);
            chk("resp_err", i, re[i], err[i]);
          end
        end
        hs[i] = rv[i] && resp_ready[i];
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) if (hs[i]) done[i] = 1'b1;
    end
    for (int i = 0; i < 2; i++) if (!done[i]) chk("timeout", i, 0, 1);
    req_valid = 1'b0;
    resp_ready[0] = 1'b0;
    resp_ready[1] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_signed = 1'b0;
    req_size = 2'd0;
    req_addr = '0;
    req_data = '0;
    rdata[0] = '0;
    rdata[1] = '0;
    resp_ready[0] = 1'b0;
    resp_ready[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    idle_chk("reset");
    for (int i = 0; i < 2; i++) begin
      chk("reset_we", i, we[i], 0);
      chk("reset_addr", i, ma[i], 0);
      chk("reset_be", i, be[i], 0);
      chk("reset_wd", i, wd[i], 0);
      chk("reset_rdata", i, rd[i], 0);
      chk("reset_err", i, re[i], 0);
    end
    @(posedge clk);
    #1;
    do_txn(1, 2'd0, 0, 32'h13, 64'hAB, 64'h0, 0, 0);
    do_txn(0, 2'd1, 1, 32'h22, 64'h0, 64'h8001_1234_8001_1234, 0, 0);
    do_txn(0, 2'd1, 0, 32'h22, 64'h0, 64'h8001_1234_8001_1234, 1, 0);
    do_txn(0, 2'd2, 0, 32'h21, 64'h0, 64'h1234_5678_9ABC_DEF0, 0, 1);
    do_txn(0, 2'd0, 1, 32'h0, 64'h0, 64'h7F, 0, 0);
    do_txn(1, 2'd3, 0, 32'h8, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 1);
    do_txn(0, 2'd2, 1, 32'h44, 64'h0, 64'hF000_0001_8000_0000, 4, 1);
    // reset while both units sit in WAIT: no response may follow
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size = 2'd2;
    req_addr = 32'h40;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_ready[0] = 1'b1;
    resp_ready[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      idle_chk("after_rst");
      @(posedge clk);
      #1;
    end
    resp_ready[0] = 1'b0;
    resp_ready[1] = 1'b0;
    for (int n = 0; n < 60; n++) begin
      logic [1:0] sz;
      logic [31:0] ad;
      sz = 2'($urandom);
      ad = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 1);
      do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, {$urandom, $urandom},
             {$urandom, $urandom}, -1, 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
